// File: rtl/instruction_prefetch_queue.sv
// Decoupled fetch front-end: sequential imem requests, {pc,insn} queue to decode.
// Ports: clk/reset, run enable, imem req/gnt/addr/rdata, redirect, out valid/ready.
module instruction_prefetch_queue #(
    parameter logic [31:0] START_ADDR = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_insn,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic [31:0]      redir_tgt;
    logic             inflight;
    logic             kill;
    logic [31:0]      q_pc   [FIFO_DEPTH];
    logic [31:0]      q_insn [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic accept;
    logic stop;
    logic flush;
    logic push;
    logic pop;
    logic credit;

    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign stop      = (state == RUN) & ~run;
    assign flush     = redirect_en | stop;
    assign accept    = imem_req & imem_gnt;
    assign push      = inflight & ~kill & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Queued entries plus the outstanding response must fit in the queue.
    assign credit = (count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (run)  state_nxt = RUN;
            RUN:     if (!run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        unique case (state)
            IDLE:    imem_req = 1'b0;
            RUN:     imem_req = credit & ~redirect_en & run;
            default: imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= START_ADDR;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= accept;
            // Squash a response whose request shares the flush cycle.
            kill     <= accept & flush;
            if (accept) begin
                req_pc <= fetch_pc;
            end
            if (!run) begin
                fetch_pc <= START_ADDR;
            end else if (redirect_en) begin
                fetch_pc <= redir_tgt;
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= req_pc;
            q_insn[wr_ptr] <= imem_rdata;
        end
    end

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? q_pc[rd_ptr]   : 32'd0;
    assign out_insn  = out_valid ? q_insn[rd_ptr] : 32'd0;
    assign occupancy = count;

endmodule
